// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types for the load/store unit and its D-cache bus.
//   Addr / UInt32  : 32-bit address and data words
//   MemSize        : access width (BYTE / HALF / WORD)
//   CacheReq       : LSU -> D-cache word request (valid/addr/wen/wdata)
//   CacheResp      : D-cache -> LSU response (valid/rdata/error)
package mem_lsu_pkg;

  typedef logic [31:0] Addr;
  typedef logic [31:0] UInt32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } MemSize;

  typedef struct packed {
    logic  valid;
    Addr   addr;
    logic  wen;
    UInt32 wdata;
  } CacheReq;

  typedef struct packed {
    logic  valid;
    UInt32 rdata;
    logic  error;
  } CacheResp;

  // The unused size encoding is handled like WORD everywhere.
  function automatic logic is_subword(MemSize s);
    return (s == BYTE) || (s == HALF);
  endfunction

  function automatic logic is_misaligned(Addr a, MemSize s);
    case (s)
      BYTE:    return 1'b0;
      HALF:    return a[0];
      default: return |a[1:0];
    endcase
  endfunction

  function automatic Addr word_addr(Addr a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: word bus between the LSU and the D-cache.
//   dreq       : request bundle, driven by the LSU (master)
//   dreq_ready : cache accepts dreq on a posedge where valid & ready
//   dresp      : response bundle, driven by the cache (slave)
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  CacheReq  dreq;
  logic     dreq_ready;
  CacheResp dresp;

  modport master (output dreq, input dreq_ready, input dresp);
  modport slave  (input dreq, output dreq_ready, output dresp);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane helper for the LSU.
//   ld_*  : extract BYTE/HALF/WORD from a cache word at a byte offset,
//           sign- or zero-extending to 32 bits.
//   st_*  : merge right-aligned store data into an old cache word in the
//           lanes selected by size and offset; other lanes are preserved.
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  UInt32      ld_word_i,
  input  logic [1:0] ld_off_i,
  input  MemSize     ld_size_i,
  input  logic       ld_unsigned_i,
  output UInt32      ld_data_o,
  input  UInt32      st_old_i,
  input  UInt32      st_new_i,
  input  logic [1:0] st_off_i,
  input  MemSize     st_size_i,
  output UInt32      st_data_o
);

  UInt32 ld_sh;
  UInt32 st_mask;
  UInt32 st_sh;

  always_comb begin
    ld_sh = ld_word_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      BYTE:    ld_data_o = {{24{~ld_unsigned_i & ld_sh[7]}},  ld_sh[7:0]};
      HALF:    ld_data_o = {{16{~ld_unsigned_i & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_data_o = ld_word_i;
    endcase
  end

  always_comb begin
    case (st_size_i)
      BYTE:    st_mask = 32'h0000_00FF << {st_off_i, 3'b000};
      HALF:    st_mask = 32'h0000_FFFF << {st_off_i, 3'b000};
      default: st_mask = 32'hFFFF_FFFF;
    endcase
    st_sh     = st_new_i << {st_off_i, 3'b000};
    st_data_o = (st_old_i & ~st_mask) | (st_sh & st_mask);
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: RV32 load/store unit between the memory stage and the D-cache.
// Converts byte/half/word accesses into 32-bit word accesses; sub-word
// stores become read-modify-write; misaligned accesses never reach the cache.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req_valid_i/ready_o, req_addr_i, req_wen_i, req_size_i,
//   req_unsigned_i, req_wdata_i : memory-stage request
//   resp_valid_o      : one-cycle completion pulse
//   resp_rdata_o      : extended load data (0 for stores and errors)
//   resp_error_o      : misaligned access or cache error
//   dbus              : D-cache word bus (mem_lsu_if.master)
//
// Build option: MEM_LSU_WORD_BUF_EN adds a one-entry word buffer holding the
// last word read from / written to the cache; a sub-word store hitting it
// skips the read phase. Loads always go to the cache.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  Addr        req_addr_i,
  input  logic       req_wen_i,
  input  MemSize     req_size_i,
  input  logic       req_unsigned_i,
  input  UInt32      req_wdata_i,
  output logic       resp_valid_o,
  output UInt32      resp_rdata_o,
  output logic       resp_error_o,
  mem_lsu_if.master  dbus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  logic [2:0] state_q, state_d;
  Addr        addr_q, addr_d;       // original byte address
  MemSize     size_q, size_d;
  logic       uns_q, uns_d;
  logic       st_q, st_d;           // request is a store
  UInt32      sdata_q, sdata_d;     // right-aligned store data
  Addr        daddr_q, daddr_d;     // dreq fields, held across stalls
  logic       dwen_q, dwen_d;
  UInt32      dwdata_q, dwdata_d;
  UInt32      rdata_q, rdata_d;     // last word returned by the cache
  logic       err_q, err_d;
  logic       resp_valid_q, resp_valid_d;
  UInt32      resp_rdata_q, resp_rdata_d;
  logic       resp_error_q, resp_error_d;
  logic       buf_hit;

`ifdef MEM_LSU_WORD_BUF_EN
  logic       buf_vld_q, buf_vld_d;
  Addr        buf_addr_q, buf_addr_d;
  UInt32      buf_data_q, buf_data_d;

  assign buf_hit = buf_vld_q && (buf_addr_q == word_addr(req_addr_i));
`else
  assign buf_hit = 1'b0;
`endif

  // Merge source: normally the word just read; in IDLE (buffer build) the
  // buffered word, so a hitting store can go straight to WR_REQ.
  UInt32      st_old, st_new, st_merged, ld_data;
  logic [1:0] st_off;
  MemSize     st_size;

  always_comb begin
    st_old  = dbus.dresp.rdata;
    st_new  = sdata_q;
    st_off  = addr_q[1:0];
    st_size = size_q;
`ifdef MEM_LSU_WORD_BUF_EN
    if (state_q == IDLE) begin
      st_old  = buf_data_q;
      st_new  = req_wdata_i;
      st_off  = req_addr_i[1:0];
      st_size = req_size_i;
    end
`endif
  end

  mem_lane_align u_align (
    .ld_word_i     (rdata_q),
    .ld_off_i      (addr_q[1:0]),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_data_o     (ld_data),
    .st_old_i      (st_old),
    .st_new_i      (st_new),
    .st_off_i      (st_off),
    .st_size_i     (st_size),
    .st_data_o     (st_merged)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    st_d         = st_q;
    sdata_d      = sdata_q;
    daddr_d      = daddr_q;
    dwen_d       = dwen_q;
    dwdata_d     = dwdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
`ifdef MEM_LSU_WORD_BUF_EN
    buf_vld_d    = buf_vld_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
`endif
    case (state_q)
      IDLE: if (req_valid_i) begin
        addr_d  = req_addr_i;
        size_d  = req_size_i;
        uns_d   = req_unsigned_i;
        st_d    = req_wen_i;
        sdata_d = req_wdata_i;
        err_d   = 1'b0;
        if (is_misaligned(req_addr_i, req_size_i)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          daddr_d = word_addr(req_addr_i);
          if (!req_wen_i || (is_subword(req_size_i) && !buf_hit)) begin
            dwen_d  = 1'b0;
            state_d = RD_REQ;
          end else begin
            dwen_d   = 1'b1;
            dwdata_d = is_subword(req_size_i) ? st_merged : req_wdata_i;
            state_d  = WR_REQ;
          end
        end
      end
      RD_REQ: if (dbus.dreq_ready) state_d = RD_WAIT;
      RD_WAIT: if (dbus.dresp.valid) begin
        rdata_d = dbus.dresp.rdata;
        if (dbus.dresp.error) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
`ifdef MEM_LSU_WORD_BUF_EN
          buf_vld_d  = 1'b1;
          buf_addr_d = daddr_q;
          buf_data_d = dbus.dresp.rdata;
`endif
          if (st_q) begin
            dwen_d   = 1'b1;
            dwdata_d = st_merged;
            state_d  = WR_REQ;
          end else begin
            state_d  = RESP;
          end
        end
      end
      WR_REQ: if (dbus.dreq_ready) state_d = WR_WAIT;
      WR_WAIT: if (dbus.dresp.valid) begin
        err_d   = dbus.dresp.error;
        state_d = RESP;
`ifdef MEM_LSU_WORD_BUF_EN
        if (!dbus.dresp.error) begin
          buf_vld_d  = 1'b1;
          buf_addr_d = daddr_q;
          buf_data_d = dwdata_q;
        end
`endif
      end
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_error_d = err_q;
        resp_rdata_d = (st_q || err_q) ? 32'h0 : ld_data;
`ifdef MEM_LSU_WORD_BUF_EN
        if (err_q) buf_vld_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= BYTE;
      uns_q        <= 1'b0;
      st_q         <= 1'b0;
      sdata_q      <= '0;
      daddr_q      <= '0;
      dwen_q       <= 1'b0;
      dwdata_q     <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
`ifdef MEM_LSU_WORD_BUF_EN
      buf_vld_q    <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      st_q         <= st_d;
      sdata_q      <= sdata_d;
      daddr_q      <= daddr_d;
      dwen_q       <= dwen_d;
      dwdata_q     <= dwdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
`ifdef MEM_LSU_WORD_BUF_EN
      buf_vld_q    <= buf_vld_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
`endif
    end
  end

  // valid is decoded from state; the payload comes straight from registers.
  CacheReq dreq_w;
  always_comb begin
    dreq_w       = '0;
    dreq_w.valid = (state_q == RD_REQ) || (state_q == WR_REQ);
    dreq_w.addr  = daddr_q;
    dreq_w.wen   = dwen_q;
    dreq_w.wdata = dwdata_q;
  end
  assign dbus.dreq = dreq_w;

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_error_o = resp_error_q;

endmodule
